sync_fifo_ext: RTL
==================

# sync_fifo_ext

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO in this codebase for same-domain buffering. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock. Storage is an internal register array.

## Interface
- Width, 8: data word width in bits.
- Depth, 512: number of entries; must be a power of two, at least 4. AddrLines = $clog2(Depth).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFThresh, Depth-4: AlmostFull asserts when Count >= AFThresh. Legal range is 1..Depth.
- AEThresh, 4: AlmostEmpty asserts when Count <= AEThresh. Legal range is 0..Depth-1.

- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous empty request.
- WRreq  input  1  write request.
- WRdata  input  Width  write data.
- RDreq  input  1  read request (pop).
- ErrClr  input  1  synchronous clear of the sticky error flags.
- RDdata  output  Width  read data.
- RDvalid  output  1  RDdata holds a valid word (see Operation).
- FIFOfull  output  1  Count == Depth.
- FIFOempty  output  1  Count == 0.
- AlmostFull  output  1  Count >= AFThresh.
- AlmostEmpty  output  1  Count <= AEThresh.
- Count  output  AddrLines+1  number of words stored.
- Overflow  output  1  sticky: a write was attempted while full.
- Underflow  output  1  sticky: a read was attempted while empty.

## Operation
- **Reset** (reset = 0, asynchronous):
  - Pointers and Count go to 0. RDdata goes to 0 in standard mode.
  - Output values during reset: RDvalid = 0, FIFOfull = 0, FIFOempty = 1, AlmostFull = 0, AlmostEmpty = 1, Overflow = 0, Underflow = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words immediately.
- **Write acceptance:** wr_ok = WRreq & !FIFOfull & !flush. On wr_ok, mem[wrptr] <= WRdata and wrptr increments.
- **Read acceptance:** rd_ok = RDreq & !FIFOempty & !flush. On rd_ok, rdptr increments.
- **Pointers:** each pointer is AddrLines bits wide and wraps Depth-1 -> 0 by natural overflow.
- **Count update:** +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- **Full:** a write is never accepted while full, even if a read occurs in the same cycle.
- **Empty:** a read is never accepted while empty. A simultaneous write is accepted.
- All status flags are combinational decodes of the registered Count. They are therefore glitch-free relative to clk.
- **Standard mode (FWFT = 0):**
  - On rd_ok, RDdata <= mem[rdptr] and RDvalid <= 1 for exactly one cycle.
  - Without rd_ok, RDvalid <= 0 and RDdata holds its last value.
- **FWFT mode (FWFT = 1):**
  - RDdata = mem[rdptr] combinationally.
  - RDvalid = !FIFOempty.
  - RDreq acts as a pop/acknowledge of the word currently shown.
- **Flush:**
  - Synchronous. Sets pointers and Count to 0 and RDvalid to 0 at the next edge.
  - Takes priority over WRreq and RDreq in the same cycle: both are ignored and neither error flag is set.
  - Does not clear Overflow or Underflow.
- **Error flags:**
  - Overflow <= 1 on WRreq & FIFOfull & !flush.
  - Underflow <= 1 on RDreq & FIFOempty & !flush.
  - ErrClr clears both flags. If a set and ErrClr occur in the same cycle, the set wins.

## Timing
- **Write-to-visible latency:** a word written at edge N is reflected in Count/FIFOempty after edge N.
  - FWFT mode: the word appears on RDdata in cycle N+1 if the FIFO was empty.
  - Standard mode: the earliest RDreq that can read it is sampled at edge N+1; data appears after that edge.
- **Standard read latency:** 1 cycle from the RDreq-sampling edge to RDdata/RDvalid.
- **Sustained throughput:** one write and one read per cycle with no bubbles when 0 < Count < Depth.
- **Flags after an edge:** FIFOfull asserts in the cycle after the edge that makes Count = Depth. FIFOempty deasserts in the cycle after the first write into an empty FIFO.

## Test plan
Configuration for all scenarios: Width=8, Depth=8, AFThresh=6, AEThresh=2.
- **Fill:** reset, then write 0x01..0x08 on 8 consecutive cycles.
  - AlmostEmpty drops after the 3rd write. AlmostFull rises after the 6th. FIFOfull = 1 and Count = 8 after the 8th.
  - A 9th WRreq sets Overflow and leaves Count = 8.
- **Drain, standard mode:** from full, RDreq held for 9 cycles.
  - RDdata shows 0x01..0x08 on the cycles after the 1st..8th reads, with RDvalid = 1 on each.
  - FIFOempty = 1 after the 8th read. The 9th read sets Underflow with RDvalid = 0.
- **Wrap and simultaneous:** run 20 cycles of concurrent WRreq/RDreq with incrementing data starting from Count = 3.
  - Count stays at 3 throughout. Output order is preserved across the pointer wrap.
  - At full, WRreq+RDreq gives Count 8 -> 7 and the write is rejected. At empty, WRreq+RDreq gives Count 0 -> 1 and the read is rejected.
- **FWFT (FWFT=1):** write 0xA5 into an empty FIFO.
  - The next cycle shows RDvalid = 1 and RDdata = 0xA5 with no RDreq.
  - RDreq pops it and RDvalid = 0 on the following cycle.
- **Flush:** with Count = 5, assert flush together with WRreq and RDreq.
  - Next cycle: Count = 0, FIFOempty = 1, RDvalid = 0, no error flag set.
  - A subsequent write of 0x3C is read back first.
- **Reset mid-operation and ErrClr:** with Count = 4 and Overflow = 1, pulse reset low between clock edges.
  - All outputs go to their reset values immediately.
  - Separately, ErrClr together with an overflowing write leaves Overflow = 1.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, selectable registered or first-word-fall-through read, and sticky error flags.
module sync_fifo_ext #(
   parameter int Width    = 8,
   parameter int Depth    = 512,
   parameter int FWFT     = 0,
   parameter int AFThresh = Depth - 4,
   parameter int AEThresh = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     WRreq,
   input  logic [Width-1:0]         WRdata,
   input  logic                     RDreq,
   input  logic                     ErrClr,
   output logic [Width-1:0]         RDdata,
   output logic                     RDvalid,
   output logic                     FIFOfull,
   output logic                     FIFOempty,
   output logic                     AlmostFull,
   output logic                     AlmostEmpty,
   output logic [$clog2(Depth):0]   Count,
   output logic                     Overflow,
   output logic                     Underflow
);

   localparam int AddrLines = $clog2(Depth);
   localparam logic [AddrLines:0] DEPTH_C = (AddrLines+1)'(Depth);
   localparam logic [AddrLines:0] AF_C    = (AddrLines+1)'(AFThresh);
   localparam logic [AddrLines:0] AE_C    = (AddrLines+1)'(AEThresh);

   logic [Width-1:0]     mem [Depth];
   logic [AddrLines-1:0] wr_ptr;
   logic [AddrLines-1:0] rd_ptr;
   logic [AddrLines:0]   count_q;
   logic                 wr_ok;
   logic                 rd_ok;
   logic                 ovf_set;
   logic                 unf_set;

   // Flags decode only registered state, so they never glitch within a cycle.
   assign FIFOfull    = (count_q == DEPTH_C);
   assign FIFOempty   = (count_q == '0);
   assign AlmostFull  = (count_q >= AF_C);
   assign AlmostEmpty = (count_q <= AE_C);
   assign Count       = count_q;

   assign wr_ok   = WRreq & ~FIFOfull  & ~flush;
   assign rd_ok   = RDreq & ~FIFOempty & ~flush;
   assign ovf_set = WRreq & FIFOfull  & ~flush;
   assign unf_set = RDreq & FIFOempty & ~flush;

   // Storage is never reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= WRdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // A set in the same cycle as ErrClr wins so no error event is ever lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         if (ovf_set) begin
            Overflow <= 1'b1;
         end else if (ErrClr) begin
            Overflow <= 1'b0;
         end
         if (unf_set) begin
            Underflow <= 1'b1;
         end else if (ErrClr) begin
            Underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign RDdata  = mem[rd_ptr];
         assign RDvalid = ~FIFOempty;
      end else begin : g_std
         logic [Width-1:0] rd_data_p1;
         logic             rd_vld_p1;

         // Registered read stage: one cycle from the popping edge to the output.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rd_data_p1 <= '0;
               rd_vld_p1  <= 1'b0;
            end else if (rd_ok) begin
               rd_data_p1 <= mem[rd_ptr];
               rd_vld_p1  <= 1'b1;
            end else begin
               rd_vld_p1  <= 1'b0;
            end
         end

         assign RDdata  = rd_data_p1;
         assign RDvalid = rd_vld_p1;
      end
   endgenerate

endmodule
